// File: rtl/bit_clmul_ctrl_pkg.sv
// Shared types for the clmul issue/retire controller.
// BIT_CLMUL_CACHE_EN adds the one-entry result cache fields.
package bit_clmul_ctrl_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    typedef struct packed {
        logic clmulr;
        logic clmulh;
        logic clmul;
    } clmul_op_type;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        BUSY  = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4
    } bit_clmul_ctrl_state_type;

    typedef struct packed {
        bit_clmul_ctrl_state_type state;
        clmul_op_type             op;
        logic [XLEN-1:0]          rdata1;
        logic [XLEN-1:0]          rdata2;
        logic [RADDR_W-1:0]       waddr;
        logic [XLEN-1:0]          result;
`ifdef BIT_CLMUL_CACHE_EN
        logic                     c_valid;
        clmul_op_type             c_op;
        logic [XLEN-1:0]          c_rdata1;
        logic [XLEN-1:0]          c_rdata2;
        logic [XLEN-1:0]          c_result;
`endif
    } bit_clmul_ctrl_reg_type;

    // IDLE encodes as zero, so all-zero is the reset image
    localparam bit_clmul_ctrl_reg_type init_bit_clmul_ctrl_reg = '0;

    function automatic logic op_legal(input clmul_op_type op);
        return $onehot(op);
    endfunction

endpackage

// File: rtl/bit_clmul_ctrl.sv
// Issue/retire controller in front of the multi-cycle clmul unit.
// Optional one-entry result cache: define BIT_CLMUL_CACHE_EN.
module bit_clmul_ctrl
    import bit_clmul_ctrl_pkg::*;
(
    input  logic               rst,
    input  logic               clk,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [2:0]         ex_op,
    input  logic [XLEN-1:0]    ex_rdata1,
    input  logic [XLEN-1:0]    ex_rdata2,
    input  logic [RADDR_W-1:0] ex_waddr,
    input  logic               flush,
    output logic               clmul_enable,
    output logic [2:0]         clmul_op,
    output logic [XLEN-1:0]    clmul_rdata1,
    output logic [XLEN-1:0]    clmul_rdata2,
    input  logic [XLEN-1:0]    clmul_result,
    input  logic               clmul_ready,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [RADDR_W-1:0] wb_waddr,
    output logic [XLEN-1:0]    wb_wdata
);

    bit_clmul_ctrl_reg_type r;
    bit_clmul_ctrl_reg_type rin;

    clmul_op_type req_op;
    logic         accept;
    logic         legal;

    assign req_op = clmul_op_type'(ex_op);
    assign accept = ex_valid & (r.state == IDLE) & ~flush;
    assign legal  = op_legal(req_op);

`ifdef BIT_CLMUL_CACHE_EN
    logic hit;
    assign hit = r.c_valid
               & (r.c_op == req_op)
               & (r.c_rdata1 == ex_rdata1)
               & (r.c_rdata2 == ex_rdata2);
`endif

    always_comb begin
        bit_clmul_ctrl_reg_type v;
        v = r;
        unique case (r.state)
            IDLE: begin
                if (accept) begin
                    v.op     = req_op;
                    v.rdata1 = ex_rdata1;
                    v.rdata2 = ex_rdata2;
                    v.waddr  = ex_waddr;
                    if (!legal) begin
                        v.result = '0;
                        v.state  = HOLD;
                    end
`ifdef BIT_CLMUL_CACHE_EN
                    else if (hit) begin
                        v.result = r.c_result;
                        v.state  = HOLD;
                    end
`endif
                    else begin
                        v.state = ISSUE;
                    end
                end
            end
            ISSUE: begin
                v.state = flush ? DRAIN : BUSY;
            end
            BUSY: begin
                // a flush racing the completion simply drops it
                if (flush) begin
                    v.state = clmul_ready ? IDLE : DRAIN;
                end else if (clmul_ready) begin
                    v.result = clmul_result;
                    v.state  = HOLD;
`ifdef BIT_CLMUL_CACHE_EN
                    v.c_valid  = 1'b1;
                    v.c_op     = r.op;
                    v.c_rdata1 = r.rdata1;
                    v.c_rdata2 = r.rdata2;
                    v.c_result = clmul_result;
`endif
                end
            end
            DRAIN: begin
                if (clmul_ready) begin
                    v.state = IDLE;
                end
            end
            HOLD: begin
                if (flush || wb_ready) begin
                    v.state = IDLE;
                end
            end
            default: begin
                v.state = IDLE;
            end
        endcase
        rin = v;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r <= init_bit_clmul_ctrl_reg;
        end else begin
            r <= rin;
        end
    end

    assign ex_ready     = (r.state == IDLE);
    assign clmul_enable = (r.state == ISSUE);
    assign clmul_op     = r.op;
    assign clmul_rdata1 = r.rdata1;
    assign clmul_rdata2 = r.rdata2;
    assign wb_valid     = (r.state == HOLD);
    assign wb_waddr     = r.waddr;
    assign wb_wdata     = r.result;

endmodule
